// File: rtl/window_stream_gen_if.sv
// Pixel-in / window-out stream bundle for window_stream_gen; slave is the generator's view.
// Combinational bundle, no latency. Backpressure via in_ready and win_ready.
interface window_stream_gen_if #(
    parameter int DATA_W = 8,
    parameter int WIN    = 6,
    parameter int CW     = 9,
    parameter int RW     = 9
);
    logic [DATA_W-1:0]         in_data;
    logic                      in_sof;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIN*WIN*DATA_W-1:0] win_data;
    logic [RW-1:0]             win_row;
    logic [CW-1:0]             win_col;
    logic                      win_valid;
    logic                      win_ready;
    logic                      frame_done;

    modport master (
        output in_data, in_sof, in_valid, win_ready,
        input  in_ready, win_data, win_row, win_col, win_valid, frame_done
    );

    modport slave (
        input  in_data, in_sof, in_valid, win_ready,
        output in_ready, win_data, win_row, win_col, win_valid, frame_done
    );
endinterface

// File: rtl/window_stream_gen.sv
// Raster pixel stream -> WIN x WIN sliding window anchored bottom-right; ZERO_PAD_EN emits border windows too.
// Latency 1 clk from pixel accept to window valid; 1 pixel/clk sustained.
// Backpressure: in_ready = !win_valid | win_ready; output regs hold while stalled.
module window_stream_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 480,
    parameter int IMG_H  = 480,
    parameter int WIN    = 6
) (
    input  logic                clk,
    input  logic                reset,
    window_stream_gen_if.slave  io
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int NB = WIN - 1;
    localparam int PW = (NB > 1) ? $clog2(NB) : 1;

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0] win_q [WIN][WIN];
    logic [DATA_W-1:0] win_d [WIN][WIN];
    logic [RW-1:0]     wrow_q, wrow_d;
    logic [CW-1:0]     wcol_q, wcol_d;
    logic              wvld_q, wvld_d;
    logic              fdone_q, fdone_d;

    logic [DATA_W-1:0] lb_mem [NB][IMG_W];

    logic              in_rdy;
    logic              acc;
    logic [CW-1:0]     cur_col;
    logic [RW-1:0]     cur_row;
    logic              emittable;
    logic [DATA_W-1:0] col_in [WIN];
    logic [WIN*WIN*DATA_W-1:0] win_flat;

    // Buffer holding window row r: ptr_q holds the oldest row (about to be overwritten).
    function automatic logic [PW-1:0] rd_idx(input logic [PW-1:0] ptr, input int r);
        int sum;
        sum = int'(ptr) + r;
        if (sum >= NB) sum = sum - NB;
        return PW'(sum);
    endfunction

    always_comb begin
        in_rdy  = !wvld_q || io.win_ready;
        acc     = io.in_valid && in_rdy;
        cur_col = io.in_sof ? '0 : col_q;
        cur_row = io.in_sof ? '0 : row_q;
`ifdef ZERO_PAD_EN
        emittable = 1'b1;
`else
        emittable = (cur_row >= RW'(WIN-1)) && (cur_col >= CW'(WIN-1));
`endif
        for (int r = 0; r < NB; r++) begin
            col_in[r] = lb_mem[rd_idx(ptr_q, r)][cur_col];
        end
        col_in[WIN-1] = io.in_data;
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        wrow_d  = wrow_q;
        wcol_d  = wcol_q;
        wvld_d  = wvld_q && !io.win_ready;
        fdone_d = wvld_q && io.win_ready &&
                  (wrow_q == RW'(IMG_H-1)) && (wcol_q == CW'(IMG_W-1));
        if (acc) begin
            if (cur_col == CW'(IMG_W-1)) begin
                col_d = '0;
                row_d = (cur_row == RW'(IMG_H-1)) ? '0 : cur_row + RW'(1);
                ptr_d = (ptr_q == PW'(NB-1)) ? '0 : ptr_q + PW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN-1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][WIN-1] = col_in[r];
            end
            wrow_d = cur_row;
            wcol_d = cur_col;
            wvld_d = emittable;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q   <= '0;
            row_q   <= '0;
            ptr_q   <= '0;
            wrow_q  <= '0;
            wcol_q  <= '0;
            wvld_q  <= 1'b0;
            fdone_q <= 1'b0;
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            ptr_q   <= ptr_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
            wvld_q  <= wvld_d;
            fdone_q <= fdone_d;
            win_q   <= win_d;
        end
    end

    // Line buffers carry no reset; rows are always rewritten before a window uses them.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb_mem[ptr_q][cur_col] <= io.in_data;
        end
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                win_flat[(r*WIN+c)*DATA_W +: DATA_W] = win_q[r][c];
`ifdef ZERO_PAD_EN
                if ((int'(wrow_q) < WIN-1-r) || (int'(wcol_q) < WIN-1-c)) begin
                    win_flat[(r*WIN+c)*DATA_W +: DATA_W] = '0;
                end
`endif
            end
        end
    end

    assign io.in_ready   = in_rdy;
    assign io.win_data   = win_flat;
    assign io.win_row    = wrow_q;
    assign io.win_col    = wcol_q;
    assign io.win_valid  = wvld_q;
    assign io.frame_done = fdone_q;
endmodule

// File: tb/tb_window_stream_gen.sv
// Bench for window_stream_gen (8x6 image, 3x3 window): window model from a stored image, random backpressure/gaps.
module tb_window_stream_gen;
    localparam int DW  = 8;
    localparam int IW  = 8;
    localparam int IH  = 6;
    localparam int WN  = 3;
    localparam int WDW = WN*WN*DW;
`ifdef ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam int NWIN = PAD ? IW*IH : (IW-WN+1)*(IH-WN+1);
    localparam int PART = PAD ? 19 : 1;

    localparam logic [WDW-1:0] L22 = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
    localparam logic [WDW-1:0] L57 = {8'h57, 8'h56, 8'h55, 8'h47, 8'h46, 8'h45, 8'h37, 8'h36, 8'h35};
    localparam logic [WDW-1:0] L17 = {8'h17, 8'h16, 8'h15, 8'h07, 8'h06, 8'h05, 8'h00, 8'h00, 8'h00};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_stream_gen_if #(.DATA_W(DW), .WIN(WN), .CW(3), .RW(3)) bus ();

    window_stream_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .WIN(WN)) dut (
        .clk   (clk),
        .reset (rst_n),
        .io    (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input bit ok, input string name, input logic [WDW-1:0] act, input logic [WDW-1:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int             row;
        int             col;
        logic [WDW-1:0] data;
    } win_t;

    win_t           exp_q[$];
    logic [DW-1:0]  img [IH][IW];
    logic [WDW-1:0] seen_win [IH][IW];
    int             m_row = 0;
    int             m_col = 0;
    int             win_count = 0;
    int             fd_count = 0;
    bit             fd_exp = 0;
    bit             hold_p = 0;
    logic [WDW-1:0] hold_d;
    logic [5:0]     hold_rc;
    int             rdy_mode = 0;

    function automatic logic [WDW-1:0] model_win(input int rr0, input int cc0);
        logic [WDW-1:0] w;
        w = '0;
        for (int r = 0; r < WN; r++) begin
            for (int c = 0; c < WN; c++) begin
                int rr;
                int cc;
                rr = rr0 - (WN-1-r);
                cc = cc0 - (WN-1-c);
                if (rr >= 0 && cc >= 0) w[(r*WN+c)*DW +: DW] = img[rr][cc];
            end
        end
        return w;
    endfunction

    function automatic bit is_emit(input int r, input int c);
        return PAD || (r >= WN-1 && c >= WN-1);
    endfunction

    // Single compare process: all output checks and model updates happen at the falling edge.
    always @(negedge clk) begin
        bit   nfd;
        win_t e;
        nfd = 1'b0;
        if (!rst_n) begin
            exp_q.delete();
            m_row = 0;
            m_col = 0;
            fd_exp = 1'b0;
            hold_p = 1'b0;
        end else begin
            chk(bus.in_ready == (!bus.win_valid || bus.win_ready), "in_ready",
                WDW'(bus.in_ready), WDW'(!bus.win_valid || bus.win_ready));
            chk(bus.frame_done == fd_exp, "frame_done", WDW'(bus.frame_done), WDW'(fd_exp));
            if (bus.frame_done) fd_count++;
            if (hold_p) begin
                chk(bus.win_data == hold_d && {bus.win_row, bus.win_col} == hold_rc, "hold_stable",
                    bus.win_data, hold_d);
            end
            if (bus.win_valid) begin
                chk(exp_q.size() != 0, "window_expected", WDW'(bus.win_valid), '0);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    chk(bus.win_data == e.data, "win_data", bus.win_data, e.data);
                    chk(int'(bus.win_row) == e.row && int'(bus.win_col) == e.col, "win_coord",
                        WDW'({bus.win_row, bus.win_col}), WDW'(e.row*256 + e.col));
                    seen_win[e.row][e.col] = bus.win_data;
                    if (bus.win_ready) begin
                        void'(exp_q.pop_front());
                        win_count++;
                        nfd = (e.row == IH-1 && e.col == IW-1);
                    end
                end
            end
            fd_exp = nfd;
            hold_p = bus.win_valid && !bus.win_ready;
            hold_d = bus.win_data;
            hold_rc = {bus.win_row, bus.win_col};
            if (bus.in_valid && bus.in_ready) begin
                if (bus.in_sof) begin
                    m_row = 0;
                    m_col = 0;
                end
                img[m_row][m_col] = bus.in_data;
                if (is_emit(m_row, m_col)) begin
                    e.row = m_row;
                    e.col = m_col;
                    e.data = model_win(m_row, m_col);
                    exp_q.push_back(e);
                end
                m_col++;
                if (m_col == IW) begin
                    m_col = 0;
                    m_row++;
                    if (m_row == IH) m_row = 0;
                end
            end
        end
    end

    initial begin
        bus.win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.win_ready = 1'b1;
                1:       bus.win_ready = !bus.win_ready;
                default: bus.win_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_pixel(input logic [DW-1:0] d, input bit sof);
        bit acc;
        int n;
        n = 0;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = sof;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = bus.in_ready && rst_n;
            n++;
            @(posedge clk);
            #1;
        end
        chk(acc, "accept_timeout", WDW'(n), WDW'(64));
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit sof0, input bit gaps, input bit rnd);
        for (int k = 0; k < n; k++) begin
            logic [DW-1:0] v;
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            v = rnd ? DW'($urandom) : DW'((k / IW) * 16 + (k % IW));
            send_pixel(v, sof0 && k == 0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.win_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(n < 500, "drain_timeout", WDW'(n), WDW'(500));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_counts(input string name, input int bw, input int bf, input int ew, input int ef);
        chk(win_count - bw == ew, {name, "_windows"}, WDW'(win_count - bw), WDW'(ew));
        chk(fd_count - bf == ef, {name, "_frame_done"}, WDW'(fd_count - bf), WDW'(ef));
    endtask

    initial begin
        int bw;
        int bf;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;

        #12;
        chk(bus.win_valid == 1'b0, "rst_win_valid", WDW'(bus.win_valid), '0);
        chk(bus.frame_done == 1'b0, "rst_frame_done", WDW'(bus.frame_done), '0);
        chk(bus.win_data == '0, "rst_win_data", bus.win_data, '0);
        chk(bus.win_row == '0 && bus.win_col == '0, "rst_coord", WDW'({bus.win_row, bus.win_col}), '0);
        chk(bus.in_ready == 1'b1, "rst_in_ready", WDW'(bus.in_ready), WDW'(1));
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp frame, downstream always ready
        rdy_mode = 0;
        bw = win_count; bf = fd_count;
        send_frame(IW*IH, 1'b1, 1'b0, 1'b0);
        drain();
        check_counts("t1", bw, bf, NWIN, 1);
        chk(seen_win[2][2] == L22, "t1_win_2_2", seen_win[2][2], L22);
        chk(seen_win[5][7] == L57, "t1_win_5_7", seen_win[5][7], L57);
`ifdef ZERO_PAD_EN
        chk(seen_win[0][0] == '0, "t5_win_0_0", seen_win[0][0], '0);
        chk(seen_win[1][7] == L17, "t5_win_1_7", seen_win[1][7], L17);
`endif

        // Ready toggles every cycle
        rdy_mode = 1;
        bw = win_count; bf = fd_count;
        send_frame(IW*IH, 1'b1, 1'b0, 1'b0);
        drain();
        check_counts("t2", bw, bf, NWIN, 1);

        // sof on the 20th pixel abandons the partial frame
        rdy_mode = 2;
        bw = win_count; bf = fd_count;
        send_frame(19, 1'b1, 1'b0, 1'b0);
        send_frame(IW*IH, 1'b1, 1'b0, 1'b0);
        drain();
        check_counts("t3", bw, bf, PART + NWIN, 1);

        // Asynchronous reset between clock edges mid-frame
        rdy_mode = 0;
        send_frame(30, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk(bus.win_valid == 1'b0, "t4_async_win_valid", WDW'(bus.win_valid), '0);
        chk(bus.frame_done == 1'b0, "t4_async_frame_done", WDW'(bus.frame_done), '0);
        chk(bus.win_row == '0 && bus.win_col == '0, "t4_async_coord", WDW'({bus.win_row, bus.win_col}), '0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        bw = win_count; bf = fd_count;
        send_frame(IW*IH, 1'b0, 1'b0, 1'b0);
        drain();
        check_counts("t4", bw, bf, NWIN, 1);
        chk(seen_win[2][2] == L22, "t4_win_2_2", seen_win[2][2], L22);

        // Two back-to-back frames, random backpressure
        rdy_mode = 2;
        bw = win_count; bf = fd_count;
        send_frame(IW*IH, 1'b1, 1'b0, 1'b0);
        send_frame(IW*IH, 1'b1, 1'b0, 1'b0);
        drain();
        check_counts("t6", bw, bf, 2*NWIN, 2);

        // Random pixels with random input gaps
        bw = win_count; bf = fd_count;
        send_frame(IW*IH, 1'b1, 1'b1, 1'b1);
        drain();
        check_counts("t7", bw, bf, NWIN, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
